// File: rtl/com_tracker_pkg.sv
// Shared widths and state encoding for the centroid tracker.
package com_tracker_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t ACQUIRE = 2'd1;
  localparam state_t LOCKED  = 2'd2;

endpackage

// File: rtl/ema_axis.sv
// One axis of the tracker: clamp, signed difference to the estimate,
// jump gate and exponential-moving-average next value, all combinational.
module ema_axis #(
  parameter int WIDTH       = 11,
  parameter int ALPHA_SHIFT = 2,
  parameter int JUMP_THRESH = 128,
  parameter int BOUND       = 1024
) (
  input  logic [WIDTH-1:0] raw,
  input  logic [WIDTH-1:0] est,
  output logic [WIDTH-1:0] clamped,
  output logic [WIDTH-1:0] next_est,
  output logic             ok
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(BOUND - 1);
  localparam logic [WIDTH:0]   THRESH = (WIDTH + 1)'(JUMP_THRESH);

  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] step;
  logic        [WIDTH:0] mag;

  // The floored step always lands between est and the sample, so the
  // truncated sum cannot wrap.
  always_comb begin
    clamped  = (raw > MAX_V) ? MAX_V : raw;
    diff     = $signed({1'b0, clamped}) - $signed({1'b0, est});
    mag      = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    ok       = (mag <= THRESH);
    step     = diff >>> ALPHA_SHIFT;
    next_est = est + step[WIDTH-1:0];
  end

endmodule

// File: rtl/com_tracker.sv
// Gated, EMA-smoothed centroid tracker with acquire/lock/lost state machine,
// fed once per frame by the center-of-mass stage.
module com_tracker
  import com_tracker_pkg::*;
#(
  parameter int ALPHA_SHIFT = 2,
  parameter int JUMP_THRESH = 128,
  parameter int LOCK_FRAMES = 3,
  parameter int LOST_FRAMES = 8,
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  input  logic           valid_in,
  input  logic           frame_tick_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           valid_out,
  output logic           locked_out,
  output logic [1:0]     state_out
);

  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);
  localparam logic [7:0] LOST_N = 8'(LOST_FRAMES);

  state_t         state, state_n;
  logic [7:0]     hit_cnt, hit_n, hit_inc;
  logic [7:0]     miss_cnt, miss_n;
  logic           frame_hit, fhit_n;
  logic [X_W-1:0] x_n, xc, x_ema;
  logic [Y_W-1:0] y_n, yc, y_ema;
  logic           x_ok, y_ok, valid_n;

  ema_axis #(.WIDTH(X_W), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_THRESH(JUMP_THRESH),
             .BOUND(H_ACTIVE)) u_x (
    .raw(x_in), .est(x_out), .clamped(xc), .next_est(x_ema), .ok(x_ok)
  );

  ema_axis #(.WIDTH(Y_W), .ALPHA_SHIFT(ALPHA_SHIFT), .JUMP_THRESH(JUMP_THRESH),
             .BOUND(V_ACTIVE)) u_y (
    .raw(y_in), .est(y_out), .clamped(yc), .next_est(y_ema), .ok(y_ok)
  );

  assign hit_inc   = (hit_cnt >= LOCK_N) ? LOCK_N : hit_cnt + 8'd1;
  assign state_out = state;

  // The sample is resolved before frame accounting so a coincident
  // accepted sample credits the frame being closed.
  always_comb begin
    state_n = state;
    hit_n   = hit_cnt;
    miss_n  = miss_cnt;
    fhit_n  = frame_hit;
    x_n     = x_out;
    y_n     = y_out;
    valid_n = 1'b0;
    case (state)
      IDLE: begin
        if (valid_in) begin
          x_n     = xc;
          y_n     = yc;
          valid_n = 1'b1;
          hit_n   = 8'd1;
          state_n = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (valid_in) begin
          valid_n = 1'b1;
          fhit_n  = 1'b1;
          if (x_ok && y_ok) begin
            x_n   = x_ema;
            y_n   = y_ema;
            hit_n = hit_inc;
            if (hit_inc >= LOCK_N) begin
              state_n = LOCKED;
              miss_n  = 8'd0;
            end
          end else begin
            x_n   = xc;
            y_n   = yc;
            hit_n = 8'd1;
          end
        end
      end
      LOCKED: begin
        if (valid_in && x_ok && y_ok) begin
          x_n     = x_ema;
          y_n     = y_ema;
          valid_n = 1'b1;
          fhit_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && frame_tick_in) begin
      miss_n = fhit_n ? 8'd0 : ((miss_n >= LOST_N) ? LOST_N : miss_n + 8'd1);
      fhit_n = 1'b0;
      if (miss_n >= LOST_N) begin
        state_n = IDLE;
        hit_n   = 8'd0;
        miss_n  = 8'd0;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      hit_cnt    <= 8'd0;
      miss_cnt   <= 8'd0;
      frame_hit  <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      valid_out  <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_n;
      hit_cnt    <= hit_n;
      miss_cnt   <= miss_n;
      frame_hit  <= fhit_n;
      x_out      <= x_n;
      y_out      <= y_n;
      valid_out  <= valid_n;
      locked_out <= (state_n == LOCKED);
    end
  end

endmodule

// File: tb/tb_com_tracker.sv
// Self-checking bench for com_tracker: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_com_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic        valid_in = 1'b0;
  logic        frame_tick_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic        locked_out;
  logic [1:0]  state_out;

  int compared = 0;
  int mismatched = 0;

  // Model of the tracker expressed with plain integers.
  int m_state, m_x, m_y, m_hit, m_miss, m_fhit, m_valid;

  typedef struct {
    logic        valid;
    logic        tick;
    logic [10:0] x;
    logic [9:0]  y;
    logic [10:0] ex;
    logic [9:0]  ey;
    logic        ev;
    logic        el;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[6];

  com_tracker dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .frame_tick_in(frame_tick_in),
    .x_out(x_out), .y_out(y_out), .valid_out(valid_out),
    .locked_out(locked_out), .state_out(state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input int ex, input int ey, input int ev,
                          input int el, input int es);
    checkOutput({tag, ".x"}, int'(x_out), ex);
    checkOutput({tag, ".y"}, int'(y_out), ey);
    checkOutput({tag, ".valid"}, int'(valid_out), ev);
    checkOutput({tag, ".locked"}, int'(locked_out), el);
    checkOutput({tag, ".state"}, int'(state_out), es);
  endtask

  // Inputs are held across one rising edge, then outputs settle 1 ns later.
  task automatic applyStimulus(input logic v, input logic t, input logic [10:0] x,
                               input logic [9:0] y);
    valid_in      = v;
    frame_tick_in = t;
    x_in          = x;
    y_in          = y;
    @(posedge clk_in);
    #1;
    valid_in      = 1'b0;
    frame_tick_in = 1'b0;
  endtask

  function automatic int ema(input int est, input int c);
    int d, q;
    d = c - est;
    q = (d >= 0) ? d / 4 : -((-d + 3) / 4);
    return est + q;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic modelReset();
    m_state = 0; m_x = 0; m_y = 0; m_hit = 0; m_miss = 0; m_fhit = 0; m_valid = 0;
  endtask

  task automatic modelStep(input int v, input int t, input int xi, input int yi);
    int xc, yc, prev;
    bit cons;
    xc = (xi > 1023) ? 1023 : xi;
    yc = (yi > 767) ? 767 : yi;
    cons = (iabs(xc - m_x) <= 128) && (iabs(yc - m_y) <= 128);
    prev = m_state;
    m_valid = 0;
    if (v != 0) begin
      if (m_state == 0) begin
        m_x = xc; m_y = yc; m_valid = 1; m_hit = 1; m_state = 1;
      end else if (m_state == 1) begin
        m_valid = 1; m_fhit = 1;
        if (cons) begin
          m_x = ema(m_x, xc); m_y = ema(m_y, yc);
          m_hit = (m_hit + 1 > 3) ? 3 : m_hit + 1;
          if (m_hit == 3) begin m_state = 2; m_miss = 0; end
        end else begin
          m_x = xc; m_y = yc; m_hit = 1;
        end
      end else if (cons) begin
        m_x = ema(m_x, xc); m_y = ema(m_y, yc); m_valid = 1; m_fhit = 1;
      end
    end
    if (prev != 0 && t != 0) begin
      if (m_fhit != 0) m_miss = 0;
      else m_miss = (m_miss + 1 > 8) ? 8 : m_miss + 1;
      m_fhit = 0;
      if (m_miss >= 8) begin m_state = 0; m_hit = 0; m_miss = 0; end
    end
  endtask

  initial begin
    int xi, yi, v, t;

    // Reset held while samples arrive: nothing may move.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 11'd300 + 11'(i), 10'd200);
      checkAll("reset_hold", 0, 0, 0, 0, 0);
    end
    rst_in = 1'b1;
    applyStimulus(1'b0, 1'b0, 11'd0, 10'd0);
    checkAll("reset_release", 0, 0, 0, 0, 0);

    // Acquire, lock, outlier rejection and negative step (last one on a tick).
    tbl[0] = '{1'b1, 1'b0, 11'd500, 10'd400, 11'd500, 10'd400, 1'b1, 1'b0, 2'd1};
    tbl[1] = '{1'b1, 1'b0, 11'd508, 10'd400, 11'd502, 10'd400, 1'b1, 1'b0, 2'd1};
    tbl[2] = '{1'b1, 1'b0, 11'd508, 10'd400, 11'd503, 10'd400, 1'b1, 1'b1, 2'd2};
    tbl[3] = '{1'b1, 1'b0, 11'd900, 10'd400, 11'd503, 10'd400, 1'b0, 1'b1, 2'd2};
    tbl[4] = '{1'b1, 1'b1, 11'd500, 10'd400, 11'd502, 10'd400, 1'b1, 1'b1, 2'd2};
    tbl[5] = '{1'b0, 1'b0, 11'd0,   10'd0,   11'd502, 10'd400, 1'b0, 1'b1, 2'd2};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].valid, tbl[i].tick, tbl[i].x, tbl[i].y);
      checkAll($sformatf("vec%0d", i), int'(tbl[i].ex), int'(tbl[i].ey),
               int'(tbl[i].ev), int'(tbl[i].el), int'(tbl[i].es));
    end

    // Loss: eight empty frames drop the lock on the eighth; a ninth is ignored.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b1, 11'd0, 10'd0);
      if (i < 8) checkAll($sformatf("loss_tick%0d", i), 502, 400, 0, 1, 2);
      else       checkAll($sformatf("loss_tick%0d", i), 502, 400, 0, 0, 0);
    end

    // Clamp in IDLE, then lock on the clamped corner.
    applyStimulus(1'b1, 1'b0, 11'd1500, 10'd900);
    checkAll("clamp", 1023, 767, 1, 0, 1);
    applyStimulus(1'b1, 1'b0, 11'd1023, 10'd767);
    checkAll("clamp_acq", 1023, 767, 1, 0, 1);
    applyStimulus(1'b1, 1'b0, 11'd1023, 10'd767);
    checkAll("clamp_lock", 1023, 767, 1, 1, 2);

    // Coincident consistent samples must keep crediting their frames.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 11'd1023, 10'd767);
      checkAll($sformatf("coinc%0d", i), 1023, 767, 1, 1, 2);
    end

    // Reset landing while valid_out is high clears it immediately.
    applyStimulus(1'b1, 1'b0, 11'd1020, 10'd760);
    checkOutput("inflight.valid_before", int'(valid_out), 1);
    rst_in = 1'b0;
    #1;
    checkAll("inflight_reset", 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 11'd100, 10'd100);
    checkAll("inflight_hold", 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    modelReset();

    // Randomized traffic: dense samples first, then sparse ones to force losses.
    for (int i = 0; i < 3000; i++) begin
      v = (i < 1500) ? int'($urandom_range(0, 9) < 6) : int'($urandom_range(0, 19) == 0);
      t = int'($urandom_range(0, 5) == 0);
      if (m_state != 0 && $urandom_range(0, 9) < 7) begin
        xi = m_x + int'($urandom_range(0, 300)) - 150;
        yi = m_y + int'($urandom_range(0, 300)) - 150;
        if (xi < 0) xi = 0;
        if (yi < 0) yi = 0;
        if (xi > 2047) xi = 2047;
        if (yi > 1023) yi = 1023;
      end else begin
        xi = int'($urandom_range(0, 2047));
        yi = int'($urandom_range(0, 1023));
      end
      applyStimulus(v[0], t[0], xi[10:0], yi[9:0]);
      modelStep(v, t, xi, yi);
      checkAll($sformatf("rand%0d", i), m_x, m_y, m_valid, int'(m_state == 2), m_state);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/com_tracker.md
Name: com_tracker

Overview:
- Sits directly downstream of the center-of-mass stage on the 65 MHz video clock.
- Consumes the once-per-frame raw centroid pulse and produces a gated, exponentially smoothed centroid plus a lock indication.
- Its outputs feed the crosshair and sprite-position logic in place of the raw latched centroid.

Parameters:
- ALPHA_SHIFT, 2: EMA weight; est += (in - est) >>> ALPHA_SHIFT. Legal range 0..4.
- JUMP_THRESH, 128: max |dx| and max |dy| (pixels, inclusive) for a sample to be accepted as consistent.
- LOCK_FRAMES, 3: consecutive consistent samples needed to enter LOCKED.
- LOST_FRAMES, 8: missed frames that force return to IDLE.
- H_ACTIVE, 1024: x clamp bound; x clamps to H_ACTIVE-1.
- V_ACTIVE, 768: y clamp bound; y clamps to V_ACTIVE-1.

Ports:
- clk_in, input, 1: 65 MHz pixel clock.
- rst_in, input, 1: asynchronous, active-low reset (0 = reset).
- x_in, input, 11: raw centroid x.
- y_in, input, 10: raw centroid y.
- valid_in, input, 1: one-cycle pulse; x_in/y_in are valid this cycle.
- frame_tick_in, input, 1: one-cycle pulse at hcount==0 && vcount==0.
- x_out, output, 11: smoothed x.
- y_out, output, 10: smoothed y.
- valid_out, output, 1: one-cycle pulse coincident with an x_out/y_out update.
- locked_out, output, 1: high while in LOCKED.
- state_out, output, 2: IDLE=0, ACQUIRE=1, LOCKED=2.

Behaviour:
- Reset (async assert, sync release): x_out=0, y_out=0, valid_out=0, locked_out=0, state IDLE, hit_cnt=0, miss_cnt=0, frame_hit=0.
- Input clamp, applied first, combinationally: xc = min(x_in, H_ACTIVE-1); yc = min(y_in, V_ACTIVE-1).
- Gate: consistent iff |xc - x_out| <= JUMP_THRESH and |yc - y_out| <= JUMP_THRESH. Differences are computed signed at 12 bits (x) and 11 bits (y).
- EMA: new = est + ((c - est) >>> ALPHA_SHIFT), using an arithmetic shift (floor). The result always lies between est and c, so no overflow or clamp is needed.
- Latency: a valid_in at edge N updates x_out/y_out at edge N+1. valid_out is high for exactly the cycle after edge N+1.
- State machine:
  - IDLE, on valid_in: load est = (xc, yc) directly; valid_out; hit_cnt=1; go to ACQUIRE.
  - ACQUIRE, valid_in consistent: EMA update; valid_out; hit_cnt++. If hit_cnt reaches LOCK_FRAMES, go to LOCKED and clear miss_cnt.
  - ACQUIRE, valid_in inconsistent: reload est = (xc, yc); valid_out; hit_cnt=1; stay in ACQUIRE.
  - LOCKED, valid_in consistent: EMA update; valid_out; the frame is credited.
  - LOCKED, valid_in inconsistent: rejected. No update, no valid_out, and the frame is not credited.
  - LOCKED with LOST_FRAMES=0 is not legal; the parameter must be >= 1.
- Frame accounting:
  - frame_hit is set by any accepted sample in ACQUIRE or LOCKED.
  - On frame_tick_in: if frame_hit==0, miss_cnt++, else miss_cnt=0. frame_hit then clears.
  - miss_cnt reaching LOST_FRAMES in ACQUIRE or LOCKED: go to IDLE, hit_cnt=0, miss_cnt=0. locked_out falls on the following edge. x_out/y_out hold their last values.
- Simultaneous valid_in and frame_tick_in: the sample is evaluated first and credits the frame being closed, so a consistent coincident sample does not increment miss_cnt.
- Back-to-back valid_in on consecutive cycles: each is processed fully against the registered estimate. No drop, no stall.
- hit_cnt saturates at LOCK_FRAMES.
- miss_cnt saturates at LOST_FRAMES.
- frame_tick_in in IDLE: ignored.
- Reset asserted mid-update: all state returns to reset values immediately. A valid_out in flight is suppressed.
- locked_out equals (state==LOCKED), registered.

Decomposition:
- Package com_tracker_pkg: state enum (IDLE, ACQUIRE, LOCKED); width constants X_W=11, Y_W=10.
- Sub-module ema_axis, parameterised by WIDTH, ALPHA_SHIFT, JUMP_THRESH, BOUND. It provides clamp, signed diff, gate compare and EMA next-value, all combinational.
- ema_axis is instantiated once for x and once for y. The FSM, counters and output registers stay in com_tracker.

Test Plan:
1. Reset: hold rst_in=0 mid-stream with valid_in pulsing -> x_out=0, y_out=0, valid_out=0, state_out=0 throughout; release -> still IDLE.
2. Acquire/lock (ALPHA_SHIFT=2):
   - valid (500,400) -> next cycle x_out=500, y_out=400, valid_out=1, state=1.
   - (508,400) -> x_out=502.
   - (508,400) -> x_out=503, state=2, locked_out=1.
3. Outlier and negative step, from LOCKED at 503:
   - (900,400), dx=397 -> no valid_out; x_out stays 503.
   - (500,400) -> diff -3 >>>2 = -1 -> x_out=502.
4. Loss: locked, then 8 frame_tick_in with no valid_in -> locked_out falls after the 8th tick, state=0, x_out held at 502. A 9th tick has no effect.
5. Clamp and coincidence:
   - In IDLE, x_in=1500, y_in=900 -> x_out=1023, y_out=767.
   - In LOCKED, consistent valid_in in the same cycle as frame_tick_in -> miss_cnt stays 0 (check via 8 further ticks with one coincident sample each: stays locked).
